// File: rtl/cve2_counter_reader_pkg.sv
// Shared types and constants for the counter read port.
//
// Contents:
//   cnt_rd_addr_e  word select on addr_i (LO / HI / DELTA / reserved)
//   rd_state_e     request/response state
//   AgeWidth       age counter width for the default snapshot timeout
//   age_width()    age counter width for any timeout (at least 1 bit)
package cve2_counter_reader_pkg;

  typedef enum logic [1:0] {
    CNT_RD_LO    = 2'd0,
    CNT_RD_HI    = 2'd1,
    CNT_RD_DELTA = 2'd2,
    CNT_RD_RSVD  = 2'd3
  } cnt_rd_addr_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  localparam int unsigned SnapTimeoutDefault = 16;
  localparam int AgeWidth = $clog2(SnapTimeoutDefault + 1);

  // A zero timeout disables ageing, but the register still needs one bit.
  function automatic int age_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cve2_counter_reader.sv
// Coherent 32-bit read port onto a live 64-bit counter.
//
// A LO read latches a full 64-bit snapshot; a following HI read returns the
// upper half of that snapshot, so a LO/HI pair never tears across a carry.
// An unconsumed snapshot expires after SnapTimeout cycles (0 = never).
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous, active-high reset
//   counter_val_i  live counter value (bits >= CounterWidth are ignored)
//   req_i/addr_i   read request and word select (0=LO 1=HI 2=DELTA 3=rsvd)
//   gnt_o          request accepted this cycle (high while idle)
//   rvalid_o       response valid; rdata_o/err_o held until rready_i
//   rready_i       response consumed
//   rdata_o/err_o  read data / error response
//   snap_vld_o     snapshot currently valid
//
// Build option: define CVE2_COUNTER_READER_DELTA_EN to make address 2 return
// the low 32 bits of (snapshot - previous snapshot). Without it address 2
// behaves like the reserved address.
module cve2_counter_reader
  import cve2_counter_reader_pkg::*;
#(
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned SnapTimeout  = SnapTimeoutDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] counter_val_i,
  input  logic        req_i,
  input  logic [1:0]  addr_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        snap_vld_o
);

  localparam int AgeW = age_width(SnapTimeout);
  localparam logic [AgeW-1:0] AgeLast = AgeW'(SnapTimeout - 1);
  localparam logic [AgeW-1:0] AgeMax  = AgeW'(SnapTimeout);
  localparam logic [63:0] CntMask = {64{1'b1}} >> (64 - CounterWidth);

  rd_state_e      state_q, state_d;
  cnt_rd_addr_e   addr;
  logic [63:0]    cv;
  logic           accept, lo_acc, hi_acc;
  logic [63:0]    snap_q;
  logic           snap_vld_q;
  logic [AgeW-1:0] age_q;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

`ifdef CVE2_COUNTER_READER_DELTA_EN
  logic [63:0]    prev_snap_q;
`endif

  assign cv     = counter_val_i & CntMask;
  assign addr   = cnt_rd_addr_e'(addr_i);
  assign accept = req_i && gnt_o;
  assign lo_acc = accept && (addr == CNT_RD_LO);
  assign hi_acc = accept && (addr == CNT_RD_HI);

  // NOTE: every signal written in a combinational block gets a default at the
  // top so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    gnt_o    = 1'b0;
    rvalid_o = 1'b0;
    case (state_q)
      RD_IDLE: begin
        gnt_o = 1'b1;
        if (req_i) state_d = RD_RESP;
      end
      RD_RESP: begin
        rvalid_o = 1'b1;
        if (rready_i) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Response word loaded at the accept cycle.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    case (addr)
      CNT_RD_LO: rdata_d = cv[31:0];
      // A valid snapshot wins even in the cycle it would otherwise expire.
      CNT_RD_HI: rdata_d = snap_vld_q ? snap_q[63:32] : cv[63:32];
      CNT_RD_DELTA: begin
`ifdef CVE2_COUNTER_READER_DELTA_EN
        rdata_d = snap_q[31:0] - prev_snap_q[31:0];
`else
        err_d   = 1'b1;
`endif
      end
      default: err_d = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      age_q      <= '0;
    end else if (lo_acc) begin
      snap_q     <= cv;
      snap_vld_q <= 1'b1;
      age_q      <= '0;
    end else if (hi_acc) begin
      snap_vld_q <= 1'b0;
    end else if (snap_vld_q && (SnapTimeout != 0)) begin
      if (age_q != AgeMax) age_q <= age_q + 1'b1;
      if (age_q == AgeLast) snap_vld_q <= 1'b0;
    end
  end

`ifdef CVE2_COUNTER_READER_DELTA_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_snap_q <= '0;
    end else if (lo_acc) begin
      prev_snap_q <= snap_q;
    end
  end
`endif

  assign rdata_o    = rdata_q;
  assign err_o      = err_q;
  assign snap_vld_o = snap_vld_q;

endmodule

// File: tb/tb_cve2_counter_reader.sv
// Self-checking bench for cve2_counter_reader (CounterWidth=40, SnapTimeout=4).
// Directed scenarios followed by randomized traffic, all compared against a
// transaction-level model: the snapshot is valid while it has not been
// consumed or overwritten and fewer than SnapTimeout edges have passed since
// the LO read that took it.
module tb_cve2_counter_reader;

  localparam int CW = 40;
  localparam int ST = 4;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] counter_val_i;
  logic        req_i;
  logic [1:0]  addr_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        snap_vld_o;

  cve2_counter_reader #(
    .CounterWidth(CW),
    .SnapTimeout (ST)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .counter_val_i(counter_val_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rready_i     (rready_i),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .snap_vld_o   (snap_vld_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [63:0] m_snap, m_prev;
  bit          m_taken;
  int          m_snap_edge;
  int          edge_cnt = 0;
  bit          m_busy;
  logic [31:0] m_rdata;
  bit          m_err;
  logic [63:0] cnt;

  function automatic bit m_vld();
    return m_taken && (ST == 0 || (edge_cnt - m_snap_edge) < ST);
  endfunction

  // One clock: drive inputs, step the model at the edge, compare at negedge.
  task automatic tick(input bit rst, input bit req, input logic [1:0] addr,
                      input bit rdy, input logic [63:0] cval);
    logic [63:0] cv;
    bit vld;
    rst_i = rst; req_i = req; addr_i = addr; rready_i = rdy; counter_val_i = cval;
    cv  = cval & MASK;
    vld = m_vld();
    @(posedge clk_i);
    edge_cnt++;
    if (rst) begin
      m_snap = '0; m_prev = '0; m_taken = 0; m_busy = 0; m_rdata = '0; m_err = 0;
    end else if (m_busy) begin
      if (rdy) m_busy = 0;
    end else if (req) begin
      m_busy = 1;
      m_err  = 0;
      case (addr)
        2'd0: begin
          m_rdata = cv[31:0];
          m_prev = m_snap; m_snap = cv; m_taken = 1; m_snap_edge = edge_cnt;
        end
        2'd1: begin
          if (vld) begin m_rdata = m_snap[63:32]; m_taken = 0; end
          else m_rdata = cv[63:32];
        end
        2'd2: begin
`ifdef CVE2_COUNTER_READER_DELTA_EN
          m_rdata = m_snap[31:0] - m_prev[31:0];
`else
          m_rdata = '0; m_err = 1;
`endif
        end
        default: begin m_rdata = '0; m_err = 1; end
      endcase
    end
    @(negedge clk_i);
    check("gnt", gnt_o, !m_busy);
    check("rvalid", rvalid_o, m_busy);
    check("snap_vld", snap_vld_o, m_vld());
    if (m_busy) begin
      check("rdata", rdata_o, m_rdata);
      check("err", err_o, m_err);
    end
  endtask

  // Issue a read, check it, then consume it; counter advances by one per cycle.
  task automatic read(input logic [1:0] addr, output logic [31:0] data, output logic err);
    tick(0, 1, addr, 0, cnt); cnt++;
    data = rdata_o; err = err_o;
    tick(0, 0, 2'd0, 1, cnt); cnt++;
  endtask

  logic [31:0] d, first;
  logic        e;

  initial begin
    m_snap = '0; m_prev = '0; m_taken = 0; m_busy = 0; m_rdata = '0; m_err = 0;
    cnt = 64'h0;

    // Reset state.
    tick(1, 0, 2'd0, 0, cnt);
    tick(1, 1, 2'd0, 0, cnt);
    check("rst_gnt", gnt_o, 1'b1);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_err", err_o, 1'b0);
    check("rst_snap_vld", snap_vld_o, 1'b0);

`ifdef CVE2_COUNTER_READER_DELTA_EN
    read(2'd2, d, e);
    check("delta_after_rst", d, 32'h0);
`endif

    // Coherent LO/HI across a carry: HI accepted 3 edges after LO.
    cnt = 64'h0000_0001_FFFF_FFFE;
    read(2'd0, d, e);
    check("coh_lo", d, 32'hFFFF_FFFE);
    tick(0, 0, 2'd0, 0, cnt); cnt++;
    read(2'd1, d, e);
    check("coh_hi", d, 32'h0000_0001);
    check("coh_snap_gone", snap_vld_o, 1'b0);

    // Expiry with SnapTimeout=4: valid for 4 edges after the LO accept.
    cnt = 64'h0000_0012_3456_7890;
    read(2'd0, d, e);
    for (int k = 2; k <= 6; k++) begin
      tick(0, 0, 2'd0, 0, cnt); cnt++;
      check($sformatf("exp_vld_k%0d", k), snap_vld_o, (k < ST));
    end
    cnt = 64'h0000_0077_0000_0000;
    read(2'd1, d, e);
    check("exp_hi_live", d, 32'h0000_0077);

    // Backpressure: rready low for 5 cycles with req held.
    tick(0, 1, 2'd0, 0, cnt); first = rdata_o; cnt++;
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 2'd1, 0, cnt); cnt++;
      check("bp_rvalid", rvalid_o, 1'b1);
      check("bp_gnt", gnt_o, 1'b0);
      check("bp_stable", rdata_o, first);
    end
    tick(0, 0, 2'd0, 1, cnt);
    check("bp_idle", gnt_o, 1'b1);

    // Width mask (CounterWidth=40).
    cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    read(2'd0, d, e);
    check("mask_lo", d, 32'hFFFF_FFFF);
    cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    read(2'd1, d, e);
    check("mask_hi", d, 32'h0000_00FF);

    // Reserved address leaves the snapshot alone.
    read(2'd0, d, e);
    read(2'd3, d, e);
    check("rsvd_rdata", d, 32'h0);
    check("rsvd_err", e, 1'b1);
    check("rsvd_snap_kept", snap_vld_o, 1'b1);

    // DELTA between two LO reads.
    cnt = 64'h100;
    read(2'd0, d, e);
    cnt = 64'h1A0;
    read(2'd0, d, e);
    read(2'd2, d, e);
`ifdef CVE2_COUNTER_READER_DELTA_EN
    check("delta_rdata", d, 32'hA0);
    check("delta_err", e, 1'b0);
`else
    check("delta_rdata", d, 32'h0);
    check("delta_err", e, 1'b1);
`endif

    // Reset while a response is pending.
    tick(0, 1, 2'd0, 0, cnt);
    check("midrst_pending", rvalid_o, 1'b1);
    tick(1, 0, 2'd0, 0, cnt);
    check("midrst_rvalid", rvalid_o, 1'b0);
    check("midrst_snap", snap_vld_o, 1'b0);
    check("midrst_gnt", gnt_o, 1'b1);

    // Randomized traffic; counter mostly increments, sometimes jumps near a carry.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0: cnt = {$urandom, $urandom};
        1: cnt = {$urandom, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))};
        default: cnt++;
      endcase
      tick(($urandom_range(0, 149) == 0), $urandom_range(0, 1),
           2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0), cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
